// File: rtl/pc_fetch_if.sv
// Port bundle for pc_fetch_unit: redirect/control inputs, external next-PC mux loop,
// and fetch outputs. The master side drives requests; the fetch unit is the slave.
interface pc_fetch_if;
  logic        br_taken;
  logic [15:0] br_target;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        irq, iret, stall, halt, imem_ready;
  logic [15:0] nxt_pc;
  logic [1:0]  nxt_sel;
  logic [15:0] pc_inc, vec, br_tgt_q, jmp_tgt_q, pc;
  logic        imem_req, pc_valid, halted, irq_ack;

  modport master (
    output br_taken, br_target, jmp, jmp_target, irq, iret, stall, halt, imem_ready, nxt_pc,
    input  nxt_sel, pc_inc, vec, br_tgt_q, jmp_tgt_q, pc, imem_req, pc_valid, halted, irq_ack
  );
  modport slave (
    input  br_taken, br_target, jmp, jmp_target, irq, iret, stall, halt, imem_ready, nxt_pc,
    output nxt_sel, pc_inc, vec, br_tgt_q, jmp_tgt_q, pc, imem_req, pc_valid, halted, irq_ack
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch sequencer driving an external 4:1 next-PC mux.
// Interrupt entry/return support is built only when PC_FETCH_IRQ_EN is defined.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [15:0] IRQ_VEC   = 16'h0004
) (
  input logic       clk,
  input logic       rst_n,
  pc_fetch_if.slave bus
);
  typedef enum logic [2:0] {BOOT, FETCH, WAIT, HOLD, HALT} state_t;

  state_t      state;
  logic [15:0] pc, br_tgt, jmp_tgt;
  logic        br_pend, jmp_pend, irq_pend;
  logic        imem_req, halted;
  logic [1:0]  sel;
  logic        accept, take_br, take_jmp;

  // Redirect winner is decoded from registered pending flags only
  always_comb begin
    sel = 2'b00;
    if (irq_pend)      sel = 2'b11;
    else if (jmp_pend) sel = 2'b10;
    else if (br_pend)  sel = 2'b01;
  end

  assign accept   = imem_req & bus.imem_ready & ~bus.stall;
  assign take_jmp = accept & (sel == 2'b10);
  // A consumed jump also discards any branch that was waiting behind it
  assign take_br  = accept & ((sel == 2'b01) | (sel == 2'b10));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VEC;
      br_pend  <= 1'b0;
      jmp_pend <= 1'b0;
      br_tgt   <= 16'h0000;
      jmp_tgt  <= 16'h0000;
    end else begin
      if (accept) pc <= bus.nxt_pc;
      if (bus.br_taken) begin
        br_pend <= 1'b1;
        br_tgt  <= bus.br_target;
      end else if (take_br) begin
        br_pend <= 1'b0;
      end
      if (bus.jmp) begin
        jmp_pend <= 1'b1;
        jmp_tgt  <= bus.jmp_target;
      end else if (take_jmp) begin
        jmp_pend <= 1'b0;
      end
    end
  end

`ifdef PC_FETCH_IRQ_EN
  logic in_isr, take_irq;
  assign take_irq = accept & (sel == 2'b11);

  // Level irq re-arms only after iret has left the handler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend <= 1'b0;
      in_isr   <= 1'b0;
    end else begin
      if (take_irq)                 irq_pend <= 1'b0;
      else if (bus.irq && !in_isr)  irq_pend <= 1'b1;
      if (take_irq)      in_isr <= 1'b1;
      else if (bus.iret) in_isr <= 1'b0;
    end
  end

  assign bus.vec     = IRQ_VEC;
  assign bus.irq_ack = take_irq;
`else
  logic unused_irq;
  assign unused_irq  = ^{bus.irq, bus.iret, IRQ_VEC};
  assign irq_pend    = 1'b0;
  assign bus.vec     = 16'h0000;
  assign bus.irq_ack = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      imem_req <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH, WAIT: begin
          if (bus.halt) begin
            state    <= HALT;
            imem_req <= 1'b0;
            halted   <= 1'b1;
          end else if (bus.stall) begin
            state    <= HOLD;
            imem_req <= 1'b0;
          end else if (bus.imem_ready) begin
            state <= FETCH;
          end else begin
            state <= WAIT;
          end
        end
        HOLD: begin
          if (bus.halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (!bus.stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        HALT: begin
          if (irq_pend) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = pc;
  assign bus.pc_inc    = pc + 16'd1;
  assign bus.nxt_sel   = sel;
  assign bus.br_tgt_q  = br_tgt;
  assign bus.jmp_tgt_q = jmp_tgt;
  assign bus.imem_req  = imem_req;
  assign bus.pc_valid  = accept;
  assign bus.halted    = halted;
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VEC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter IRQ_VEC, 16'h0004, interrupt entry address.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 br_taken / br_target  in  1 / 16  branch redirect request and target.
REQ-006 jmp / jmp_target  in  1 / 16  jump redirect request and target.
REQ-007 irq / iret  in  1 / 1  interrupt request level; return-from-interrupt pulse.
REQ-008 stall  in  1  pipeline hold from downstream.
REQ-009 halt  in  1  enter halted state.
REQ-010 imem_ready  in  1  instruction memory accepts current request.
REQ-011 nxt_pc  in  16  output of the external 16-bit 4:1 next-PC mux.
REQ-012 nxt_sel  out  2  mux select: 00 pc_inc, 01 branch, 10 jump, 11 vector.
REQ-013 pc_inc / vec / br_tgt_q / jmp_tgt_q  out  16 each  mux inputs a, d, b, c.
REQ-014 pc / imem_req / pc_valid / halted / irq_ack  out  16/1/1/1/1  fetch address, request, one-cycle accept pulse, state flags.

Function
REQ-015 pc_inc SHALL equal pc+1 modulo 2^16 (16'hFFFF -> 16'h0000, no flag).
REQ-016 FSM states: BOOT, FETCH, WAIT, HOLD, HALT; BOOT lasts exactly one cycle after rst_n rises, then FETCH.
REQ-017 FETCH/WAIT: imem_req=1; accept = imem_req & imem_ready & !stall.
REQ-018 On accept: pc <= nxt_pc next edge, pc_valid=1 that cycle, state FETCH; latency accept->new pc = 1 cycle.
REQ-019 imem_req & !imem_ready & !stall -> WAIT; pc, nxt_sel held stable.
REQ-020 stall=1 in FETCH/WAIT -> HOLD; imem_req=0, pc held; stall=0 returns to FETCH.
REQ-021 Redirect priority: pending vector > jmp > br_taken > sequential; nxt_sel encodes the winner combinationally from registered pending state.
REQ-022 br_taken/jmp pulses SHALL be captured into pending flags and br_tgt_q/jmp_tgt_q on the cycle asserted, held through WAIT/HOLD, cleared on the accept that consumes them; no redirect is lost.
REQ-023 A newer request of the same kind before consumption overwrites the stored target.
REQ-024 Consumption of jmp SHALL also clear a simultaneously pending branch (jump wins, branch discarded).
REQ-025 halt=1 in FETCH/HOLD/WAIT -> HALT after any in-flight accept; HALT: imem_req=0, halted=1, pc held.
REQ-026 HALT exits to FETCH only on pending interrupt.

Reset
REQ-027 rst_n=0 SHALL immediately force: pc=RESET_VEC, state BOOT, imem_req=0, pc_valid=0, halted=0, irq_ack=0, nxt_sel=00, all pending flags and stored targets 0.
REQ-028 Reset mid-WAIT/HOLD discards pending redirects; no pc_valid after reset until first accept.

Configuration
REQ-029 Macro PC_FETCH_IRQ_EN defined: irq sets pending when not in_isr; accept with pending -> pc=IRQ_VEC, irq_ack one-cycle pulse, in_isr=1; iret clears in_isr; vec=IRQ_VEC.
REQ-030 PC_FETCH_IRQ_EN undefined: irq/iret ignored, nxt_sel never 11, irq_ack=0, vec=16'h0000, HALT exits only via reset.

Verification
REQ-031 Reset release, imem_ready=1: pc 0000 -> 0001 -> 0002, pc_valid each cycle from cycle 2, nxt_sel=00.
REQ-032 pc=16'hFFFF sequential accept -> pc=16'h0000.
REQ-033 br_taken pulse target 16'h0040 during stall=1 for 3 cycles -> after stall drops, nxt_sel=01, next pc=0040.
REQ-034 jmp(0100) and br_taken(0200) same cycle -> nxt_sel=10, pc=0100, branch discarded, following pc=0101.
REQ-035 IRQ_EN build: irq during HALT -> FETCH, pc=0004, irq_ack pulse; second irq ignored until iret.
REQ-036 rst_n asserted during WAIT with pending jump -> pc=RESET_VEC immediately, no redirect after release.
